// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce,
// decoding accepted keys into digit/confirm/cancel strobes for the code lock.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 10
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] din,
   output logic       din_valid,
   output logic       confirm,
   output logic       cancel,
   output logic       key_busy
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_EMIT     = 2'd2,
      ST_REL_DB   = 2'd3
   } state_t;

   // Codes 0-9 are digits, A-D are silent keys, E is '*', F is '#'.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'd1;
         4'h1: k = 4'd2;
         4'h2: k = 4'd3;
         4'h3: k = 4'hA;
         4'h4: k = 4'd4;
         4'h5: k = 4'd5;
         4'h6: k = 4'd6;
         4'h7: k = 4'hB;
         4'h8: k = 4'd7;
         4'h9: k = 4'd8;
         4'hA: k = 4'd9;
         4'hB: k = 4'hC;
         4'hC: k = 4'hE;
         4'hD: k = 4'd0;
         4'hE: k = 4'hF;
         4'hF: k = 4'hD;
         default: k = 4'd0;
      endcase
      return k;
   endfunction

   function automatic logic one_low(input logic [3:0] v);
      logic r;
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] r;
      case (v)
         4'b1110: r = 2'd0;
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         default: r = 2'd3;
      endcase
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       meta_q, meta_d;
   logic [3:0]       rs_q, rs_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_q, col_d;
   logic [3:0]       lat_q, lat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       din_q, din_d;
   logic             din_valid_q, din_valid_d;
   logic             confirm_q, confirm_d;
   logic             cancel_q, cancel_d;
   logic             key_busy_q, key_busy_d;
   logic             tick_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [3:0]       code_s;

   // Next-state, synchronizer, divider and strobe decode.
   always_comb begin
      state_d     = state_q;
      meta_d      = row;
      rs_d        = meta_q;
      col_idx_d   = col_idx_q;
      lat_d       = lat_q;
      cnt_d       = cnt_q;
      din_d       = din_q;
      din_valid_d = 1'b0;
      confirm_d   = 1'b0;
      cancel_d    = 1'b0;
      key_busy_d  = key_busy_q;
      tick_s      = (div_q == DIV_LAST);
      cnt_inc_s   = cnt_q + CNT_W'(1);
      code_s      = key_code(low_index(lat_q), col_idx_q);
      if (tick_s) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      case (state_q)
         ST_SCAN: begin
            if (tick_s && one_low(rs_q)) begin
               lat_d   = rs_q;
               cnt_d   = '0;
               state_d = ST_PRESS_DB;
            end else if (tick_s) begin
               col_idx_d = col_idx_q + 2'd1;
            end else begin
               state_d = ST_SCAN;
            end
         end
         ST_PRESS_DB: begin
            if (tick_s && (rs_q == lat_q)) begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == CNT_DONE) begin
                  // Strobes are launched here so they are high exactly while in EMIT.
                  state_d    = ST_EMIT;
                  key_busy_d = 1'b1;
                  if (code_s <= 4'd9) begin
                     din_d       = code_s;
                     din_valid_d = 1'b1;
                  end else if (code_s == 4'hE) begin
                     cancel_d = 1'b1;
                  end else if (code_s == 4'hF) begin
                     confirm_d = 1'b1;
                  end else begin
                     din_valid_d = 1'b0;
                  end
               end else begin
                  state_d = ST_PRESS_DB;
               end
            end else if (tick_s) begin
               state_d   = ST_SCAN;
               col_idx_d = col_idx_q + 2'd1;
            end else begin
               state_d = ST_PRESS_DB;
            end
         end
         ST_EMIT: begin
            cnt_d   = '0;
            state_d = ST_REL_DB;
         end
         ST_REL_DB: begin
            if (tick_s && (rs_q == 4'b1111)) begin
               if (cnt_inc_s == CNT_DONE) begin
                  cnt_d      = '0;
                  key_busy_d = 1'b0;
                  state_d    = ST_SCAN;
                  col_idx_d  = col_idx_q + 2'd1;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end else if (tick_s) begin
               cnt_d = '0;
            end else begin
               state_d = ST_REL_DB;
            end
         end
         default: begin
            state_d = ST_SCAN;
         end
      endcase

      col_d = ~(4'b0001 << col_idx_d);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_SCAN;
         meta_q      <= 4'b1111;
         rs_q        <= 4'b1111;
         div_q       <= '0;
         col_idx_q   <= 2'd0;
         col_q       <= 4'b1110;
         lat_q       <= 4'b1111;
         cnt_q       <= '0;
         din_q       <= 4'd0;
         din_valid_q <= 1'b0;
         confirm_q   <= 1'b0;
         cancel_q    <= 1'b0;
         key_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         meta_q      <= meta_d;
         rs_q        <= rs_d;
         div_q       <= div_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         lat_q       <= lat_d;
         cnt_q       <= cnt_d;
         din_q       <= din_d;
         din_valid_q <= din_valid_d;
         confirm_q   <= confirm_d;
         cancel_q    <= cancel_d;
         key_busy_q  <= key_busy_d;
      end
   end

   assign col       = col_q;
   assign din       = din_q;
   assign din_valid = din_valid_q;
   assign confirm   = confirm_q;
   assign cancel    = cancel_q;
   assign key_busy  = key_busy_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed and random key presses on a column-sensitive
// keypad model, with strobes checked against a key-map scoreboard.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  din;
   logic        din_valid;
   logic        confirm;
   logic        cancel;
   logic        key_busy;
   logic [15:0] pressed;

   int checks = 0;
   int errors = 0;
   int obs_q[$];
   int last_digit = 0;
   string keymap = "123A456B789C*0#D";

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk(clk), .clr(clr), .row(row), .col(col), .din(din),
      .din_valid(din_valid), .confirm(confirm), .cancel(cancel), .key_busy(key_busy)
   );

   // Keypad: a row reads low only while the column of a held key on it is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   // Expected event for key index k: 0-9 digit, 10 confirm, 11 cancel, -1 none.
   function automatic int expected_event(int k);
      byte ch;
      ch = keymap.getc(k);
      if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
      if (ch == "#") return 10;
      if (ch == "*") return 11;
      return -1;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Collect strobes and check column drive / strobe exclusivity every cycle.
   always @(negedge clk) begin
      if (!clr) begin
         checks++;
         assert (col == 4'b1110 || col == 4'b1101 || col == 4'b1011 || col == 4'b0111) else begin
            errors++;
            $error("FAIL col_onehot observed=%b expected=one-low", col);
         end
         if (din_valid || confirm || cancel) begin
            checks++;
            assert ($countones({din_valid, confirm, cancel}) == 1 && key_busy === 1'b1) else begin
               errors++;
               $error("FAIL strobe_excl observed=%b busy=%b expected=one-strobe busy=1",
                      {din_valid, confirm, cancel}, key_busy);
            end
            if (din_valid) obs_q.push_back(int'(din));
            else if (confirm) obs_q.push_back(10);
            else obs_q.push_back(11);
         end
      end
   end

   task automatic finish_key(int k, int hold, int gap);
      int e;
      e = expected_event(k);
      repeat (hold) @(posedge clk);
      #1 check("busy_held", key_busy, 1);
      pressed = 16'h0000;
      repeat (gap) @(posedge clk);
      #1 check("busy_released", key_busy, 0);
      check("strobe_count", obs_q.size(), (e >= 0) ? 1 : 0);
      if (obs_q.size() >= 1 && e >= 0) check("strobe_code", obs_q[0], e);
      obs_q.delete();
      if (e >= 0 && e <= 9) last_digit = e;
      check("din_held", din, last_digit);
   endtask

   task automatic press_release(int k, int hold, int gap);
      pressed = 16'h0001 << k;
      finish_key(k, hold, gap);
   endtask

   task automatic check_reset_outputs();
      check("rst_col", col, 4'b1110);
      check("rst_din", din, 0);
      check("rst_din_valid", din_valid, 0);
      check("rst_confirm", confirm, 0);
      check("rst_cancel", cancel, 0);
      check("rst_busy", key_busy, 0);
   endtask

   initial begin
      int seen;
      int run;
      logic held_ok;
      pressed = 16'h0000;
      clr = 1'b1;
      #1 check_reset_outputs();
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;

      press_release(5, 100, 60);
      press_release(0, 80, 60);
      press_release(1, 80, 60);
      press_release(2, 80, 60);
      press_release(4, 80, 60);
      press_release(14, 80, 60);
      press_release(12, 80, 60);
      press_release(3, 80, 60);

      // Bouncing '0' must not produce a strobe until it settles.
      for (int i = 0; i < 20; i++) begin
         pressed = (((i / 3) % 2) == 0) ? 16'h2000 : 16'h0000;
         @(posedge clk);
         #1;
      end
      check("bounce_quiet", obs_q.size(), 0);
      pressed = 16'h2000;
      finish_key(13, 80, 60);

      // Ghost: '1' and '4' share column 0.
      pressed = 16'h0011;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) if (!col[c]) seen |= (1 << c);
      end
      check("ghost_cols", seen, 15);
      check("ghost_busy", key_busy, 0);
      check("ghost_count", obs_q.size(), 0);
      obs_q.delete();
      pressed = 16'h0000;
      repeat (30) @(posedge clk);

      // Reset while '7' is being debounced, then re-accept it.
      pressed = 16'h0100;
      run = 0;
      held_ok = 1'b0;
      for (int i = 0; i < 200 && !held_ok; i++) begin
         @(negedge clk);
         if (col == 4'b1110) run++;
         else run = 0;
         if (run >= 6) held_ok = 1'b1;
      end
      check("press_db_reached", held_ok, 1);
      #2 clr = 1'b1;
      #1 check_reset_outputs();
      last_digit = 0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      check("clr_no_strobe", obs_q.size(), 0);
      finish_key(8, 100, 60);

      for (int n = 0; n < 24; n++) begin
         press_release(int'($urandom_range(0, 15)), int'($urandom_range(60, 120)),
                       int'($urandom_range(50, 90)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
